// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x 32-bit register file with same-cycle write-back bypass
// and a per-register 2-bit scoreboard of outstanding producers.
// Register 0 is hard-wired to zero and never has a pending producer.
// Reset is synchronous and active-high; it clears storage, counts and the
// sticky overflow flag, and inputs presented in a reset cycle are ignored.

module reg_file_sb (
    input  logic        clk,
    input  logic        reset,
    // write-back port from the MEM/WB stage
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_rd_data,
    // decode-stage read ports
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    // issue port: instruction leaving decode with a register destination
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    // read data and hazard status
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic [5:0]  pending_cnt,
    output logic        sb_ovf,
    // debug read port, raw stored value with no bypass
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int unsigned NUM_REGS = 32;
    localparam logic [1:0]  CNT_MAX  = 2'd3;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  cnt_t;

    // ------------------------------------------------------------------
    // Qualified write-back and issue strobes (register 0 never counts)
    // ------------------------------------------------------------------
    logic wb_en;
    logic issue_en;

    assign wb_en    = wb_regwrite && (wb_rd != 5'd0);
    assign issue_en = issue_valid && (issue_rd != 5'd0);

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    word_t regs [NUM_REGS];

    // Store write-back data; reset clears every entry.
    // NOTE: the array is built from resettable flops rather than a RAM
    // macro because a reset must clear all 31 registers in one edge; a
    // RAM could only be cleared by a multi-cycle sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: sequential state always takes <=, so every reader
                // in this edge sees the pre-edge value regardless of the
                // order in which the always blocks are evaluated.
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_rd] <= wb_rd_data;
        end
    end

    // Stored value of a register; entry 0 is forced to zero on every port.
    function automatic word_t stored_word(input logic [4:0] addr,
                                          input word_t     raw);
        return (addr == 5'd0) ? '0 : raw;
    endfunction

    // Value seen by decode: the in-flight write-back wins over storage.
    function automatic word_t read_word(input logic [4:0] addr,
                                        input word_t     raw,
                                        input logic      wen,
                                        input logic [4:0] waddr,
                                        input word_t     wdata);
        if (wen && (waddr == addr)) begin
            return wdata;
        end
        return stored_word(addr, raw);
    endfunction

    assign rs_data  = read_word(id_rs, regs[id_rs], wb_en, wb_rd, wb_rd_data);
    assign rt_data  = read_word(id_rt, regs[id_rt], wb_en, wb_rd, wb_rd_data);
    assign dbg_data = stored_word(dbg_addr, regs[dbg_addr]);

    // ------------------------------------------------------------------
    // Scoreboard: one 2-bit outstanding-producer count per register.
    // Counts live in a packed vector, two bits per register, so they can
    // be selected by a 5-bit address; slot 0 is a constant zero.
    // ------------------------------------------------------------------
    logic [2*NUM_REGS-1:0] cnt_flat;
    logic [NUM_REGS-1:0]   sat_hit;

    assign cnt_flat[1:0] = 2'b00;
    assign sat_hit[0]    = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        cnt_t cnt_q;
        cnt_t cnt_d;
        logic dec_hit;
        logic inc_hit;

        // A write-back only retires a producer when one is outstanding.
        assign dec_hit = wb_en && (wb_rd == 5'(r)) && (cnt_q != 2'd0);
        assign inc_hit = issue_en && (issue_rd == 5'(r));

        // Next count: matched issue and retire cancel; saturate at 3.
        always_comb begin
            // NOTE: default first, so every path assigns cnt_d and no
            // latch is inferred.
            cnt_d = cnt_q;
            if (inc_hit && dec_hit) begin
                cnt_d = cnt_q;
            end else if (dec_hit) begin
                cnt_d = cnt_q - 2'd1;
            end else if (inc_hit && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 2'd1;
            end
        end

        // An issue to a saturated register with no same-cycle retire.
        assign sat_hit[r] = inc_hit && !dec_hit && (cnt_q == CNT_MAX);

        // Count register; reset discards every in-flight producer.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= 2'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_flat[2*r +: 2] = cnt_q;
    end

    // Sticky overflow: set by any saturated issue, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_ovf <= 1'b0;
        end else if (|sat_hit) begin
            sb_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Busy: a source is busy while it has a producer, unless the only
    // remaining producer is writing back this very cycle (its value then
    // arrives through the bypass). A same-cycle issue is not visible yet.
    // ------------------------------------------------------------------
    cnt_t rs_cnt;
    cnt_t rt_cnt;

    assign rs_cnt = cnt_flat[{id_rs, 1'b0} +: 2];
    assign rt_cnt = cnt_flat[{id_rt, 1'b0} +: 2];

    function automatic logic busy_of(input logic [4:0] addr,
                                     input cnt_t       cnt,
                                     input logic       wen,
                                     input logic [4:0] waddr);
        logic last_retiring;
        last_retiring = wen && (waddr == addr) && (cnt == 2'd1);
        return (cnt != 2'd0) && !last_retiring;
    endfunction

    assign rs_busy = busy_of(id_rs, rs_cnt, wb_regwrite, wb_rd);
    assign rt_busy = busy_of(id_rt, rt_cnt, wb_regwrite, wb_rd);

    // Number of registers with at least one outstanding producer.
    always_comb begin
        pending_cnt = 6'd0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending_cnt = pending_cnt + 6'(|cnt_flat[2*r +: 2]);
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scenarios plus randomized traffic against a
// behavioural model of the register file and scoreboard. Every cycle the
// outputs are compared with the model half a period after the inputs move.

module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rs_busy;
    logic        rt_busy;
    logic [5:0]  pending_cnt;
    logic        sb_ovf;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_ovf;
    bit          model_ok = 1'b0;

    reg_file_sb dut (
        .clk         (clk),
        .reset       (reset),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_rd_data  (wb_rd_data),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .pending_cnt (pending_cnt),
        .sb_ovf      (sb_ovf),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read value from the model: r0 is zero, write-back bypasses.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_regwrite && wb_rd == a) return wb_rd_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (m_cnt[a] == 0) return 1'b0;
        return !(wb_regwrite && wb_rd == a && m_cnt[a] == 1);
    endfunction

    task automatic compare_all();
        int pend;
        if (!model_ok) return;
        pend = 0;
        for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) pend++;
        check("rs_data",     rs_data,     exp_read(id_rs));
        check("rt_data",     rt_data,     exp_read(id_rt));
        check("rs_busy",     rs_busy,     exp_busy(id_rs));
        check("rt_busy",     rt_busy,     exp_busy(id_rt));
        check("pending_cnt", pending_cnt, pend);
        check("sb_ovf",      sb_ovf,      m_ovf);
        check("dbg_data",    dbg_data,    m_regs[dbg_addr]);
    endtask

    // Apply the edge to the model using the inputs present at the edge.
    task automatic model_update();
        bit dec, inc;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_cnt[r]  = 0;
            end
            m_ovf    = 1'b0;
            model_ok = 1'b1;
            return;
        end
        if (!model_ok) return;
        dec = wb_regwrite && wb_rd != 0 && m_cnt[wb_rd] > 0;
        inc = issue_valid && issue_rd != 0;
        if (wb_regwrite && wb_rd != 0) m_regs[wb_rd] = wb_rd_data;
        if (inc && dec && issue_rd == wb_rd) return;
        if (dec) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
        if (inc) begin
            if (m_cnt[issue_rd] < 3) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
            else m_ovf = 1'b1;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, then release the inputs 1 time unit later.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic wr, input logic [4:0] rd,
                          input logic [31:0] data, input logic [4:0] rs,
                          input logic [4:0] rt, input logic iv,
                          input logic [4:0] ird, input logic [4:0] dbg);
        reset       = 1'b0;
        wb_regwrite = wr;
        wb_rd       = rd;
        wb_rd_data  = data;
        id_rs       = rs;
        id_rt       = rt;
        issue_valid = iv;
        issue_rd    = ird;
        dbg_addr    = dbg;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    initial begin
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b1;
        tick();

        // write-back bypass, then stored value on the debug port
        set_in(1'b1, 5'd10, 32'h2, 5'd10, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_bypass_r10", rs_data, 32'h2);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd10);
        #2 check("lit_dbg_r10", dbg_data, 32'h2);
        tick();

        // writes to register 0 are discarded
        set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r0_same", rt_data, 32'd0);
        check("lit_r0_dbg_same", dbg_data, 32'd0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r0_next", rt_data, 32'd0);
        check("lit_r0_dbg_next", dbg_data, 32'd0);
        tick();

        // issue r31, busy next cycle, retire with bypass
        set_in(1'b0, 5'd0, 32'd0, 5'd31, 5'd0, 1'b1, 5'd31, 5'd0);
        #2 check("lit_r31_issue_not_busy", rs_busy, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd31, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r31_busy", rs_busy, 1'b1);
        check("lit_r31_pend1", pending_cnt, 6'd1);
        tick();
        set_in(1'b1, 5'd31, 32'h4, 5'd31, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r31_retire_busy", rs_busy, 1'b0);
        check("lit_r31_retire_data", rs_data, 32'h4);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd31, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r31_pend0", pending_cnt, 6'd0);
        tick();

        // saturation on r5
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 5'd5, 5'd0);
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r5_busy3", rs_busy, 1'b1);
        check("lit_r5_ovf_clear", sb_ovf, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 5'd5, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r5_ovf_set", sb_ovf, 1'b1);
        tick();
        set_in(1'b1, 5'd5, 32'h55, 5'd5, 5'd0, 1'b1, 5'd5, 5'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 5'd5, 32'h50 + i, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r5_one_left", rs_busy, 1'b1);
        check("lit_r5_pend1", pending_cnt, 6'd1);
        tick();
        set_in(1'b1, 5'd5, 32'h5F, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r5_free", rs_busy, 1'b0);
        check("lit_r5_pend0", pending_cnt, 6'd0);
        check("lit_ovf_sticky", sb_ovf, 1'b1);
        tick();

        // issue and retire r7 together with one outstanding producer
        set_in(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b1, 5'd7, 5'd0);
        tick();
        set_in(1'b1, 5'd7, 32'h77, 5'd7, 5'd0, 1'b1, 5'd7, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 5'd0, 5'd0);
        #2 check("lit_r7_still_busy", rs_busy, 1'b1);
        check("lit_r7_pend1", pending_cnt, 6'd1);
        tick();
        set_in(1'b1, 5'd7, 32'h78, 5'd7, 5'd0, 1'b0, 5'd0, 5'd0);
        tick();

        // reset with r3/r4 pending discards everything
        set_in(1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b1, 5'd3, 5'd0);
        tick();
        set_in(1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b1, 5'd4, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3, 5'd3);
        reset = 1'b1;
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, 5'd0, 5'd3);
        #2 check("lit_rst_pend", pending_cnt, 6'd0);
        check("lit_rst_rs_busy", rs_busy, 1'b0);
        check("lit_rst_rt_busy", rt_busy, 1'b0);
        check("lit_rst_ovf", sb_ovf, 1'b0);
        check("lit_rst_dbg_r3", dbg_data, 32'd0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, 5'd0, 5'd4);
        #2 check("lit_rst_dbg_r4", dbg_data, 32'd0);
        tick();

        // randomized traffic, occasional reset
        for (int c = 0; c < 3000; c++) begin
            set_in(1'($urandom_range(0, 1)), pick(), $urandom(), pick(),
                   pick(), 1'($urandom_range(0, 1)), pick(), pick());
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameters: none; 32 registers x 32 bits, fixed.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 WB_REGWRITE  input  1  write-back enable from the MEM/WB stage (RegWrite).
REQ-005 WB_RD  input  5  write-back destination register.
REQ-006 WB_RD_DATA  input  32  write-back data, already muxed from ALU result, memory data or PC+4.
REQ-007 ID_RS  input  5  decode-stage source register A.
REQ-008 ID_RT  input  5  decode-stage source register B.
REQ-009 ISSUE_VALID  input  1  instruction leaving decode this cycle with a register destination.
REQ-010 ISSUE_RD  input  5  destination of the issuing instruction.
REQ-011 RS_DATA  output  32  value of ID_RS (combinational).
REQ-012 RT_DATA  output  32  value of ID_RT (combinational).
REQ-013 RS_BUSY  output  1  ID_RS has an outstanding producer; decode shall stall.
REQ-014 RT_BUSY  output  1  ID_RT has an outstanding producer; decode shall stall.
REQ-015 PENDING_CNT  output  6  number of registers with a nonzero pending count (0..31).
REQ-016 SB_OVF  output  1  sticky flag: issue attempted on a register already at count 3.
REQ-017 DBG_ADDR  input  5  debug read address.
REQ-018 DBG_DATA  output  32  stored value of DBG_ADDR, no bypass.

Function
REQ-019 Register write: rising edge with WB_REGWRITE=1 and WB_RD!=0 stores WB_RD_DATA into WB_RD; otherwise no register changes.
REQ-020 Register 0 reads 0 on every port at all times; writes to it are discarded.
REQ-021 Read bypass: if WB_REGWRITE=1, WB_RD!=0 and WB_RD equals ID_RS (ID_RT), RS_DATA (RT_DATA) is WB_RD_DATA in the same cycle; otherwise it is the stored value.
REQ-022 Scoreboard: one 2-bit pending count per register 1..31; register 0 count is permanently 0.
REQ-023 Decrement: WB_REGWRITE=1, WB_RD=r!=0, count[r]>0 -> count[r]-1 on the edge; a write to a register with count 0 changes no count.
REQ-024 Increment: ISSUE_VALID=1, ISSUE_RD=r!=0, count[r]<3 -> count[r]+1 on the edge.
REQ-025 Simultaneous increment and decrement on the same r: count unchanged; on different registers both apply.
REQ-026 Saturation: issue to r with count[r]=3 and no same-cycle decrement of r leaves count at 3 and sets SB_OVF on the edge.
REQ-027 RS_BUSY = (count[ID_RS]!=0) AND NOT (WB_REGWRITE=1, WB_RD=ID_RS, count[ID_RS]=1); same rule for RT_BUSY; always 0 for register 0.
REQ-028 The current-cycle issue does not affect RS_BUSY/RT_BUSY until the following cycle.
REQ-029 PENDING_CNT reflects registered counts (post-edge), not same-cycle inputs.
REQ-030 Latency: register write visible in stored value one edge after WB; via bypass in the same cycle.

Reset
REQ-031 On a rising edge with RESET=1: all 31 registers cleared to 0, all pending counts cleared to 0, SB_OVF cleared; WB and issue inputs in that cycle are ignored.
REQ-032 During RESET=1, RS_BUSY=RT_BUSY=0 and PENDING_CNT=0 from the first reset edge onward; RS_DATA/RT_DATA return stored (zero) values with bypass still active.
REQ-033 Reset asserted mid-operation discards all in-flight pending counts; no count survives.

Verification
REQ-034 Reset, then WB_REGWRITE=1, WB_RD=10, WB_RD_DATA=0x00000002 with ID_RS=10 -> RS_DATA=0x00000002 same cycle; next cycle with WB_REGWRITE=0, DBG_ADDR=10 -> DBG_DATA=0x00000002.
REQ-035 WB_REGWRITE=1, WB_RD=0, WB_RD_DATA=0xFFFFFFFF, ID_RT=0 -> RT_DATA=0 same and next cycle; DBG_DATA for address 0 stays 0.
REQ-036 ISSUE_VALID=1, ISSUE_RD=31 -> next cycle ID_RS=31 gives RS_BUSY=1, PENDING_CNT=1; later WB_REGWRITE=1, WB_RD=31, WB_RD_DATA=0x00000004 -> RS_BUSY=0 and RS_DATA=0x00000004 same cycle, PENDING_CNT=0 next cycle.
REQ-037 Three issues to r5 -> count 3, RS_BUSY=1 (ID_RS=5); fourth issue -> SB_OVF=1, count stays 3; issue and WB to r5 in the same cycle -> count stays 3; then three WB writes -> RS_BUSY=0, PENDING_CNT=0.
REQ-038 Issue to r7 and WB to r7 same cycle with count[7]=1 -> count stays 1, RS_BUSY stays 1 for ID_RS=7.
REQ-039 Two issues pending (r3, r4), RESET=1 for one edge -> PENDING_CNT=0, RS_BUSY=RT_BUSY=0, DBG_DATA=0 for r3 and r4, SB_OVF=0.
